// File: rtl/haar_pkg.sv
// Shared types and default geometry for the Haar pair feeder.
// Width helper keeps degenerate geometries at 1-bit counters.
package haar_pkg;

  localparam int PIX_W_D = 8;
  localparam int IMG_W_D = 512;
  localparam int IMG_H_D = 512;

  typedef enum logic [1:0] {
    WAIT_SOF,
    GET_EVEN,
    GET_ODD
  } state_t;

  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  localparam int COL_W = clog2_min1(IMG_W_D / 2);
  localparam int ROW_W = clog2_min1(IMG_H_D);

endpackage

// File: rtl/haar_pos_counter.sv
// Pair-column / row position of the next pair to be emitted.
// Decodes end-of-row and end-of-frame from the current position.
module haar_pos_counter
  import haar_pkg::*;
#(
  parameter int IMG_W = IMG_W_D,
  parameter int IMG_H = IMG_H_D,
  localparam int CW = clog2_min1(IMG_W / 2),
  localparam int RW = clog2_min1(IMG_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_adv,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic          o_eol,
  output logic          o_eof
);

  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W / 2 - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  assign o_col = r_col;
  assign o_row = r_row;
  assign o_eol = (r_col == LAST_COL);
  assign o_eof = o_eol && (r_row == LAST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_adv) begin
      if (o_eol) begin
        r_col <= '0;
        r_row <= o_eof ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/haar_pair_feeder.sv
// Groups a raster pixel stream into tagged (even, odd) pixel pairs
// held in a one-entry back-pressured output register.
module haar_pair_feeder
  import haar_pkg::*;
#(
  parameter int PIX_W = PIX_W_D,
  parameter int IMG_W = IMG_W_D,
  parameter int IMG_H = IMG_H_D,
  localparam int CW = clog2_min1(IMG_W / 2),
  localparam int RW = clog2_min1(IMG_H)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             pix_sof,
  output logic             pix_ready,
  output logic [PIX_W-1:0] a_out,
  output logic [PIX_W-1:0] b_out,
  output logic             pair_valid,
  input  logic             pair_ready,
  output logic [CW-1:0]    pair_col,
  output logic [RW-1:0]    pair_row,
  output logic             pair_eol,
  output logic             pair_eof,
  output logic             frame_err
);

  state_t           r_state;
  logic [PIX_W-1:0] r_even;
  logic [PIX_W-1:0] r_a;
  logic [PIX_W-1:0] r_b;
  logic             r_pv;
  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic             r_eol;
  logic             r_eof;
  logic             r_err;

  logic          w_acc;
  logic          w_start;
  logic          w_odd_ld;
  logic          w_err;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_eol;
  logic          w_eof;

  assign pix_ready = (r_state == GET_ODD) ?
                     (!r_pv || pair_ready) : 1'b1;

  assign w_acc    = pix_valid && pix_ready;
  assign w_start  = w_acc && pix_sof;
  assign w_odd_ld = w_acc && !pix_sof && (r_state == GET_ODD);

  // Restart is only an error once a frame is under way.
  assign w_err = w_start &&
                 ((r_state == GET_ODD) ||
                  ((r_state == GET_EVEN) &&
                   ((w_col != '0) || (w_row != '0))));

  haar_pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_start),
    .i_adv (w_odd_ld),
    .o_col (w_col),
    .o_row (w_row),
    .o_eol (w_eol),
    .o_eof (w_eof)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_SOF;
      r_even  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_err;
      unique case (r_state)
        WAIT_SOF: begin
          if (w_start) begin
            r_even  <= pix_in;
            r_state <= GET_ODD;
          end
        end
        GET_EVEN: begin
          if (w_acc) begin
            r_even  <= pix_in;
            r_state <= GET_ODD;
          end
        end
        GET_ODD: begin
          if (w_start) begin
            r_even <= pix_in;
          end else if (w_odd_ld) begin
            r_state <= w_eof ? WAIT_SOF : GET_EVEN;
          end
        end
        default: r_state <= WAIT_SOF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pv  <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
      r_col <= '0;
      r_row <= '0;
      r_eol <= 1'b0;
      r_eof <= 1'b0;
    end else if (w_odd_ld) begin
      r_pv  <= 1'b1;
      r_a   <= r_even;
      r_b   <= pix_in;
      r_col <= w_col;
      r_row <= w_row;
      r_eol <= w_eol;
      r_eof <= w_eof;
    end else if (pair_ready) begin
      r_pv <= 1'b0;
    end
  end

  assign a_out      = r_a;
  assign b_out      = r_b;
  assign pair_valid = r_pv;
  assign pair_col   = r_col;
  assign pair_row   = r_row;
  assign pair_eol   = r_eol;
  assign pair_eof   = r_eof;
  assign frame_err  = r_err;

endmodule
